// File: rtl/axi4_burst_master_if.sv
// AXI4 five-channel bundle between the burst master and a memory slave.
// Burst type is carried but the master only ever issues INCR.
interface axi4_burst_master_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 16
);
    logic [ADDR_WIDTH-1:0] AWADDR;
    logic [7:0]            AWLEN;
    logic [2:0]            AWSIZE;
    logic [1:0]            AWBURST;
    logic                  AWVALID;
    logic                  AWREADY;

    logic [DATA_WIDTH-1:0] WDATA;
    logic                  WLAST;
    logic                  WVALID;
    logic                  WREADY;

    logic [1:0]            BRESP;
    logic                  BVALID;
    logic                  BREADY;

    logic [ADDR_WIDTH-1:0] ARADDR;
    logic [7:0]            ARLEN;
    logic [2:0]            ARSIZE;
    logic [1:0]            ARBURST;
    logic                  ARVALID;
    logic                  ARREADY;

    logic [DATA_WIDTH-1:0] RDATA;
    logic [1:0]            RRESP;
    logic                  RLAST;
    logic                  RVALID;
    logic                  RREADY;

    modport master (
        output AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
        input  AWREADY,
        output WDATA, WLAST, WVALID,
        input  WREADY,
        input  BRESP, BVALID,
        output BREADY,
        output ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID,
        input  ARREADY,
        input  RDATA, RRESP, RLAST, RVALID,
        output RREADY
    );

    modport slave (
        input  AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
        output AWREADY,
        input  WDATA, WLAST, WVALID,
        output WREADY,
        output BRESP, BVALID,
        input  BREADY,
        input  ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID,
        output ARREADY,
        output RDATA, RRESP, RLAST, RVALID,
        input  RREADY
    );
endinterface

// File: rtl/axi4_burst_master.sv
// AXI4 initiator: one read or write INCR burst per local command, one outstanding at a time.
// Data channels are combinational pass-throughs of the local streams while in W / R.
module axi4_burst_master #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 16
) (
    input  logic                  ACLK,
    input  logic                  ARESETn,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [7:0]            cmd_len,
    input  logic [2:0]            cmd_size,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    input  logic                  rd_ready,
    output logic                  rd_last,
    output logic                  done,
    output logic [1:0]            done_resp,
    output logic                  done_proto_err,
    axi4_burst_master_if.master   axi
);

    typedef enum logic [2:0] {IDLE, AW, W, B, AR, R} state_t;

    state_t     state;
    logic [7:0] len;
    logic [8:0] beat_cnt;
    logic [1:0] worst_resp;
    logic       proto_err;

    logic       last_beat;
    logic       w_fire;
    logic       r_fire;
    logic [1:0] resp_next;
    logic       proto_next;

    // beat_cnt is one bit wider than len so a 256-beat burst never wraps.
    assign last_beat  = (beat_cnt == {1'b0, len});
    assign w_fire     = axi.WVALID && axi.WREADY;
    assign r_fire     = axi.RVALID && axi.RREADY;
    assign resp_next  = (axi.RRESP > worst_resp) ? axi.RRESP : worst_resp;
    assign proto_next = proto_err | (axi.RLAST != last_beat);

    assign cmd_ready   = (state == IDLE);
    assign axi.AWBURST = 2'b01;
    assign axi.ARBURST = 2'b01;

    assign axi.WVALID = (state == W) && wr_valid;
    assign axi.WDATA  = wr_data;
    assign axi.WLAST  = (state == W) && last_beat;
    assign wr_ready   = (state == W) && axi.WREADY;
    assign axi.BREADY = (state == B);

    assign rd_valid   = (state == R) && axi.RVALID;
    assign rd_data    = (state == R) ? axi.RDATA : '0;
    assign rd_last    = (state == R) && last_beat;
    assign axi.RREADY = (state == R) && rd_ready;

    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            state          <= IDLE;
            len            <= '0;
            beat_cnt       <= '0;
            worst_resp     <= 2'b00;
            proto_err      <= 1'b0;
            done           <= 1'b0;
            done_resp      <= 2'b00;
            done_proto_err <= 1'b0;
            axi.AWADDR     <= '0;
            axi.AWLEN      <= '0;
            axi.AWSIZE     <= '0;
            axi.AWVALID    <= 1'b0;
            axi.ARADDR     <= '0;
            axi.ARLEN      <= '0;
            axi.ARSIZE     <= '0;
            axi.ARVALID    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        len        <= cmd_len;
                        beat_cnt   <= '0;
                        worst_resp <= 2'b00;
                        proto_err  <= 1'b0;
                        if (cmd_write) begin
                            axi.AWADDR  <= cmd_addr;
                            axi.AWLEN   <= cmd_len;
                            axi.AWSIZE  <= cmd_size;
                            axi.AWVALID <= 1'b1;
                            state       <= AW;
                        end else begin
                            axi.ARADDR  <= cmd_addr;
                            axi.ARLEN   <= cmd_len;
                            axi.ARSIZE  <= cmd_size;
                            axi.ARVALID <= 1'b1;
                            state       <= AR;
                        end
                    end
                end
                AW: begin
                    if (axi.AWREADY) begin
                        axi.AWVALID <= 1'b0;
                        state       <= W;
                    end
                end
                W: begin
                    if (w_fire) begin
                        beat_cnt <= beat_cnt + 9'd1;
                        if (last_beat) state <= B;
                    end
                end
                B: begin
                    if (axi.BVALID) begin
                        done           <= 1'b1;
                        done_resp      <= axi.BRESP;
                        done_proto_err <= 1'b0;
                        state          <= IDLE;
                    end
                end
                AR: begin
                    if (axi.ARREADY) begin
                        axi.ARVALID <= 1'b0;
                        state       <= R;
                    end
                end
                R: begin
                    // Completion is decided by our own beat count, never by RLAST.
                    if (r_fire) begin
                        worst_resp <= resp_next;
                        proto_err  <= proto_next;
                        beat_cnt   <= beat_cnt + 9'd1;
                        if (last_beat) begin
                            done           <= 1'b1;
                            done_resp      <= resp_next;
                            done_proto_err <= proto_next;
                            state          <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi4_burst_master.sv
// Scoreboard bench for axi4_burst_master against a behavioural AXI4 memory slave (1024 words).
// Expected read data and responses come from a reference memory updated at command issue.
module tb_axi4_burst_master;
    localparam int DW        = 32;
    localparam int AWID      = 16;
    localparam int MEM_WORDS = 1024;

    typedef struct { logic write; logic [15:0] addr; logic [7:0] len; logic [2:0] size; } cmd_t;
    typedef struct { logic [31:0] data; logic last; } rd_t;
    typedef struct { logic [1:0] resp; logic proto; } done_t;

    logic            ACLK = 1'b0;
    logic            ARESETn = 1'b0;
    logic            cmd_valid, cmd_ready, cmd_write;
    logic [AWID-1:0] cmd_addr;
    logic [7:0]      cmd_len;
    logic [2:0]      cmd_size;
    logic [DW-1:0]   wr_data, rd_data;
    logic            wr_valid, wr_ready, rd_valid, rd_ready, rd_last;
    logic            done, done_proto_err;
    logic [1:0]      done_resp;

    axi4_burst_master_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AWID)) axi ();

    axi4_burst_master #(.DATA_WIDTH(DW), .ADDR_WIDTH(AWID)) dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_size(cmd_size),
        .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_last(rd_last),
        .done(done), .done_resp(done_resp), .done_proto_err(done_proto_err),
        .axi(axi)
    );

    always #5 ACLK = ~ACLK;

    int  n_checks = 0;
    int  n_pass = 0;
    int  done_count = 0;
    int  slv_rate = 100;
    int  loc_rate = 100;
    int  bad_rlast_beat = -1;
    bit  bp_mode = 1'b0;

    cmd_t        exp_cmdq[$];
    logic [31:0] wq[$];
    logic [31:0] exp_wq[$];
    rd_t         exp_rdq[$];
    done_t       exp_doneq[$];
    logic [31:0] stim_data[$];
    logic [31:0] ref_mem[int];
    logic [31:0] slv_mem[MEM_WORDS];

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic failNow(input string name);
        n_checks++;
        $display("[TB] FAIL %s: event count 0, expected 1", name);
    endtask

    function automatic bit chance(input int pct);
        return ($urandom_range(99) < pct);
    endfunction

    // A burst is rejected whole if any beat leaves the start page or the memory.
    function automatic bit refBurstErr(input logic [15:0] addr, input logic [7:0] len);
        bit err;
        int base;
        err  = 1'b0;
        base = int'(addr);
        for (int i = 0; i <= int'(len); i++) begin
            if (((base + i * 4) / 4096) != (base / 4096) || ((base + i * 4) / 4) >= MEM_WORDS)
                err = 1'b1;
        end
        return err;
    endfunction

    task automatic fillRandom(input int n);
        stim_data.delete();
        for (int i = 0; i < n; i++) stim_data.push_back($urandom);
    endtask

    task automatic applyStimulus(input bit write, input logic [15:0] addr, input logic [7:0] len,
                                 input bit track);
        int    base, start, cyc;
        bit    err, proto;
        cmd_t  c;
        rd_t   r;
        done_t d;
        base  = int'(addr);
        err   = refBurstErr(addr, len);
        start = done_count;
        c.write = write; c.addr = addr; c.len = len; c.size = 3'd2;
        exp_cmdq.push_back(c);
        proto = 1'b0;
        if (write) begin
            for (int i = 0; i <= int'(len); i++) begin
                wq.push_back(stim_data[i]);
                exp_wq.push_back(stim_data[i]);
                if (track && !err) ref_mem[base / 4 + i] = stim_data[i];
            end
        end else begin
            for (int i = 0; i <= int'(len); i++) begin
                r.data = (err || !ref_mem.exists(base / 4 + i)) ? 32'h0 : ref_mem[base / 4 + i];
                r.last = (i == int'(len));
                exp_rdq.push_back(r);
                if (bad_rlast_beat >= 0 && ((i == bad_rlast_beat) != (i == int'(len)))) proto = 1'b1;
            end
        end
        d.resp = err ? 2'b10 : 2'b00;
        d.proto = proto;
        exp_doneq.push_back(d);

        @(negedge ACLK);
        cmd_valid = 1'b1; cmd_write = write; cmd_addr = addr; cmd_len = len; cmd_size = 3'd2;
        cyc = 0;
        #1;
        while (!cmd_ready && cyc < 5000) begin @(negedge ACLK); #1; cyc++; end
        if (!cmd_ready) failNow("cmd_accept_timeout");
        @(negedge ACLK);
        cmd_valid = 1'b0;
        if (track) begin
            cyc = 0;
            while (done_count == start && cyc < 5000) begin @(negedge ACLK); cyc++; end
            if (done_count == start) failNow("done_timeout");
        end
    endtask

    // Behavioural slave plus local stream drivers: drive at negedge, observe handshakes 1ns later.
    initial begin
        int phase, s_beat, s_len, s_idx;
        bit s_err, b_fired, r_fired, tog, aw_pend, ar_pend;
        logic [15:0] s_addr, hold_aw, hold_ar;
        logic [7:0]  hold_awlen, hold_arlen;
        logic [31:0] wbuf[$];
        cmd_t c;
        phase = 0; s_beat = 0; s_len = 0; s_idx = 0; s_err = 0; s_addr = '0;
        b_fired = 0; r_fired = 0; tog = 0; aw_pend = 0; ar_pend = 0;
        hold_aw = '0; hold_ar = '0; hold_awlen = '0; hold_arlen = '0;
        for (int i = 0; i < MEM_WORDS; i++) slv_mem[i] = 32'h0;
        axi.AWREADY = 0; axi.WREADY = 0; axi.BVALID = 0; axi.BRESP = 0; axi.ARREADY = 0;
        axi.RVALID = 0; axi.RDATA = 0; axi.RRESP = 0; axi.RLAST = 0;
        wr_valid = 0; wr_data = 0; rd_ready = 0;
        forever begin
            @(negedge ACLK);
            wr_valid = (wq.size() > 0) && (bp_mode ? tog : chance(loc_rate));
            wr_data  = (wq.size() > 0) ? wq[0] : 32'h0;
            rd_ready = bp_mode ? tog : chance(loc_rate);
            tog = ~tog;
            if (b_fired) begin axi.BVALID = 0; b_fired = 0; end
            if (r_fired) begin axi.RVALID = 0; r_fired = 0; end
            axi.AWREADY = (phase == 0) && chance(slv_rate);
            axi.ARREADY = (phase == 0) && chance(slv_rate);
            axi.WREADY  = (phase == 1) && chance(slv_rate);
            if (phase == 2 && !axi.BVALID && chance(slv_rate)) begin
                axi.BVALID = 1; axi.BRESP = s_err ? 2'b10 : 2'b00;
            end
            if (phase == 3 && !axi.RVALID && chance(slv_rate)) begin
                axi.RVALID = 1;
                axi.RRESP  = s_err ? 2'b10 : 2'b00;
                axi.RDATA  = 32'h0;
                if (!s_err) axi.RDATA = slv_mem[s_idx + s_beat];
                axi.RLAST  = (bad_rlast_beat >= 0) ? (s_beat == bad_rlast_beat) : (s_beat == s_len);
            end
            #1;
            if (!ARESETn) begin
                phase = 0; axi.BVALID = 0; axi.RVALID = 0; b_fired = 0; r_fired = 0;
                aw_pend = 0; ar_pend = 0; wbuf.delete();
            end else begin
                if (aw_pend) begin
                    checkOutput("awvalid_held", axi.AWVALID, 1);
                    checkOutput("awaddr_stable", axi.AWADDR, hold_aw);
                    checkOutput("awlen_stable", axi.AWLEN, hold_awlen);
                end
                if (ar_pend) begin
                    checkOutput("arvalid_held", axi.ARVALID, 1);
                    checkOutput("araddr_stable", axi.ARADDR, hold_ar);
                    checkOutput("arlen_stable", axi.ARLEN, hold_arlen);
                end
                aw_pend = axi.AWVALID && !axi.AWREADY;
                ar_pend = axi.ARVALID && !axi.ARREADY;
                hold_aw = axi.AWADDR; hold_awlen = axi.AWLEN;
                hold_ar = axi.ARADDR; hold_arlen = axi.ARLEN;
                if ((axi.AWVALID && axi.AWREADY) || (axi.ARVALID && axi.ARREADY)) begin
                    if (exp_cmdq.size() == 0) failNow("unexpected_addr_handshake");
                    else begin
                        c = exp_cmdq.pop_front();
                        checkOutput("cmd_direction", axi.AWVALID && axi.AWREADY, c.write);
                        s_addr = axi.AWVALID ? axi.AWADDR : axi.ARADDR;
                        s_len  = axi.AWVALID ? int'(axi.AWLEN) : int'(axi.ARLEN);
                        checkOutput("axaddr", s_addr, c.addr);
                        checkOutput("axlen", s_len, c.len);
                        checkOutput("axsize", axi.AWVALID ? axi.AWSIZE : axi.ARSIZE, c.size);
                        checkOutput("axburst", axi.AWVALID ? axi.AWBURST : axi.ARBURST, 2'b01);
                        s_idx  = int'(s_addr) / 4;
                        s_err  = ((int'(s_addr[11:0]) + (s_len + 1) * 4) > 4096) ||
                                 ((s_idx + s_len) >= MEM_WORDS);
                        s_beat = 0;
                        wbuf.delete();
                        phase  = axi.AWVALID ? 1 : 3;
                    end
                end
                if (axi.WVALID && axi.WREADY) begin
                    if (phase != 1 || exp_wq.size() == 0) failNow("unexpected_w_beat");
                    else begin
                        checkOutput("wdata", axi.WDATA, exp_wq.pop_front());
                        checkOutput("wlast", axi.WLAST, s_beat == s_len);
                        wbuf.push_back(axi.WDATA);
                        s_beat++;
                        if (s_beat > s_len) phase = 2;
                    end
                end
                if (wr_valid && wr_ready && wq.size() > 0) void'(wq.pop_front());
                if (axi.BVALID && axi.BREADY) begin
                    if (!s_err) for (int i = 0; i < wbuf.size(); i++) slv_mem[s_idx + i] = wbuf[i];
                    b_fired = 1; phase = 0;
                end
                if (axi.RVALID && axi.RREADY) begin
                    r_fired = 1; s_beat++;
                    if (s_beat > s_len) phase = 0;
                end
            end
        end
    end

    // Monitor: pops the scoreboard whenever the DUT hands over a read beat or a completion.
    initial begin
        rd_t   e;
        done_t d;
        forever begin
            @(negedge ACLK);
            #2;
            if (ARESETn) begin
                if (rd_valid && rd_ready) begin
                    if (exp_rdq.size() == 0) failNow("unexpected_rd_beat");
                    else begin
                        e = exp_rdq.pop_front();
                        checkOutput("rd_data", rd_data, e.data);
                        checkOutput("rd_last", rd_last, e.last);
                    end
                end
                if (done) begin
                    if (exp_doneq.size() == 0) failNow("unexpected_done");
                    else begin
                        d = exp_doneq.pop_front();
                        checkOutput("done_resp", done_resp, d.resp);
                        checkOutput("done_proto_err", done_proto_err, d.proto);
                        checkOutput("done_vs_cmd_ready", cmd_ready, 1);
                    end
                    done_count++;
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        cmd_valid = 0; cmd_write = 0; cmd_addr = '0; cmd_len = '0; cmd_size = '0;
        repeat (3) @(negedge ACLK);
        #1;
        checkOutput("rst_cmd_ready", cmd_ready, 1);
        checkOutput("rst_awvalid", axi.AWVALID, 0);
        checkOutput("rst_arvalid", axi.ARVALID, 0);
        checkOutput("rst_wvalid", axi.WVALID, 0);
        checkOutput("rst_bready", axi.BREADY, 0);
        checkOutput("rst_rready", axi.RREADY, 0);
        checkOutput("rst_done", {done, done_resp, done_proto_err}, 0);
        checkOutput("rst_addr_fields", {axi.AWADDR, axi.AWLEN, axi.ARADDR, axi.ARLEN}, 0);
        checkOutput("rst_burst", {axi.AWBURST, axi.ARBURST}, 4'b0101);
        ARESETn = 1;

        stim_data = '{32'hA0, 32'hA1, 32'hA2, 32'hA3};
        applyStimulus(1, 16'h0010, 8'd3, 1);
        applyStimulus(0, 16'h0010, 8'd3, 1);

        stim_data = '{32'h5A5A_0001};
        applyStimulus(1, 16'h1000, 8'd0, 1);
        applyStimulus(0, 16'h1000, 8'd0, 1);
        applyStimulus(0, 16'h0FF8, 8'd3, 1);

        bp_mode = 1; slv_rate = 60;
        fillRandom(16);
        applyStimulus(1, 16'h0200, 8'd15, 1);
        applyStimulus(0, 16'h0200, 8'd15, 1);
        bp_mode = 0; slv_rate = 100;

        bad_rlast_beat = 1;
        applyStimulus(0, 16'h0010, 8'd3, 1);
        bad_rlast_beat = -1;

        fillRandom(256);
        applyStimulus(1, 16'h0400, 8'd255, 1);
        applyStimulus(0, 16'h0400, 8'd255, 1);

        bp_mode = 1;
        fillRandom(8);
        applyStimulus(1, 16'h0100, 8'd7, 0);
        repeat (4) @(negedge ACLK);
        ARESETn = 0;
        wq.delete(); exp_wq.delete(); exp_cmdq.delete(); exp_rdq.delete(); exp_doneq.delete();
        @(negedge ACLK);
        #1;
        checkOutput("midrst_awvalid", axi.AWVALID, 0);
        checkOutput("midrst_wvalid", axi.WVALID, 0);
        checkOutput("midrst_wr_ready", wr_ready, 0);
        checkOutput("midrst_bready", axi.BREADY, 0);
        checkOutput("midrst_done", done, 0);
        checkOutput("midrst_cmd_ready", cmd_ready, 1);
        ARESETn = 1;
        repeat (3) @(negedge ACLK);
        bp_mode = 0;
        applyStimulus(0, 16'h0100, 8'd7, 1);

        for (int t = 0; t < 30; t++) begin
            slv_rate = 50 + int'($urandom_range(50));
            loc_rate = 50 + int'($urandom_range(50));
            bp_mode  = ($urandom_range(3) == 0);
            fillRandom(16);
            applyStimulus($urandom_range(1) == 1, 16'(($urandom_range(16'h11FC)) & 32'hFFFC),
                          8'($urandom_range(15)), 1);
        end

        repeat (5) @(negedge ACLK);
        checkOutput("rd_queue_drained", exp_rdq.size(), 0);
        checkOutput("done_queue_drained", exp_doneq.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
